// File: rtl/scarv_cop_dispatch_pkg.sv
// Shared types for the ISE coprocessor dispatcher: FSM states, decode bundle
// layout (80 bits), instruction class codes and the class-to-FU index mapping.
package scarv_cop_dispatch_pkg;

  localparam int SCARV_COP_DISP_DEC_W = 80;

  typedef enum logic [1:0] {
    SCARV_COP_DISP_IDLE,
    SCARV_COP_DISP_ISSUE,
    SCARV_COP_DISP_WAIT,
    SCARV_COP_DISP_RSP
  } disp_state_e;

  localparam logic [6:0] SCARV_COP_OPC = 7'b0001011;

  localparam logic [3:0] CLS_PACKED_ARITH = 4'd1;
  localparam logic [3:0] CLS_TWIDDLE      = 4'd2;
  localparam logic [3:0] CLS_LOADSTORE    = 4'd3;
  localparam logic [3:0] CLS_RANDOM       = 4'd4;
  localparam logic [3:0] CLS_MOVE         = 4'd5;
  localparam logic [3:0] CLS_MP           = 4'd6;
  localparam logic [3:0] CLS_BITWISE      = 4'd7;
  localparam logic [3:0] CLS_AES          = 4'd8;
  localparam logic [3:0] CLS_SHA3         = 4'd9;

  localparam logic [2:0] SCARV_COP_PW_1  = 3'd0;
  localparam logic [2:0] SCARV_COP_PW_2  = 3'd1;
  localparam logic [2:0] SCARV_COP_PW_4  = 3'd2;
  localparam logic [2:0] SCARV_COP_PW_8  = 3'd3;
  localparam logic [2:0] SCARV_COP_PW_16 = 3'd4;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  subclass;
    logic [2:0]  pw;
    logic [3:0]  crs1;
    logic [3:0]  crs2;
    logic [3:0]  crs3;
    logic [3:0]  crd;
    logic [3:0]  crd1;
    logic [3:0]  crd2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic        wb_h;
    logic        wb_b;
  } dec_t;

  // FU ports are numbered from zero; class code 0 is reserved as "no class".
  function automatic logic [3:0] cls_to_fu(input logic [3:0] cls);
    return cls - 4'd1;
  endfunction

endpackage

// File: rtl/scarv_cop_idecode.sv
// Combinational instruction decoder for the ISE coprocessor: field extraction
// plus encoding-level legality (opcode, packed-width range).
module scarv_cop_idecode
  import scarv_cop_dispatch_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec,
  output logic        exc
);

  always_comb begin
    dec          = '0;
    dec.cls      = instr[31:28];
    dec.subclass = {1'b0, instr[27:24]};
    dec.pw       = instr[14:12];
    dec.crs1     = instr[18:15];
    dec.crs2     = instr[23:20];
    dec.crs3     = instr[27:24];
    dec.crd      = instr[10:7];
    dec.crd1     = instr[10:7];
    dec.crd2     = {instr[10:8], 1'b1};
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.imm      = {{20{instr[31]}}, instr[31:20]};
    dec.wb_h     = instr[25];
    dec.wb_b     = instr[24];
    // Packed arithmetic only defines lane widths 32..2 bits.
    exc = (instr[6:0] != SCARV_COP_OPC) ||
          ((instr[31:28] == CLS_PACKED_ARITH) && (instr[14:12] > SCARV_COP_PW_16));
  end

endmodule

// File: rtl/scarv_cop_dispatch.sv
// Single-outstanding instruction sequencer: decode, issue to one of NFU class
// units, wait for done, respond. Define SCARV_COP_DISPATCH_TIMEOUT_EN for the WAIT watchdog.
module scarv_cop_dispatch
  import scarv_cop_dispatch_pkg::*;
#(
  parameter int NFU            = 9,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CTR_W          = 11
) (
  input  logic           g_clk,
  input  logic           g_reset,
  input  logic           cpu_req_valid,
  output logic           cpu_req_ready,
  input  logic [31:0]    cpu_req_instr,
  input  logic [31:0]    cpu_req_rs1,
  output logic           cpu_rsp_valid,
  input  logic           cpu_rsp_ready,
  output logic           cpu_rsp_exc,
  output logic           cpu_rsp_wen,
  output logic [4:0]     cpu_rsp_rd,
  output logic [31:0]    cpu_rsp_wdata,
  output dec_t           iss_dec,
  output logic [31:0]    iss_rs1,
  output logic [NFU-1:0] fu_req_valid,
  input  logic [NFU-1:0] fu_req_ready,
  input  logic [NFU-1:0] fu_done,
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
  output logic [NFU-1:0] fu_abort,
`endif
  input  logic           fu_exc,
  input  logic           fu_gpr_wen,
  input  logic [31:0]    fu_gpr_wdata
);

  if (2**CTR_W <= TIMEOUT_CYCLES) begin : g_cfg_err
    $error("CTR_W too narrow for TIMEOUT_CYCLES");
  end

  disp_state_e    state_q, state_d;
  dec_t           dec;
  logic           dec_exc, bad_cls;
  logic [NFU-1:0] fu_sel;
  logic           sel_ready, sel_done;
  logic           accept, load_exc, cap_fu, timeout;
  logic           rsp_exc, rsp_wen;
  logic [31:0]    rsp_wdata;

  scarv_cop_idecode u_idecode (
    .instr (cpu_req_instr),
    .dec   (dec),
    .exc   (dec_exc)
  );

  assign bad_cls   = (dec.cls == 4'd0) || (32'(dec.cls) > NFU);
  assign fu_sel    = NFU'(1) << cls_to_fu(iss_dec.cls);
  assign sel_ready = |(fu_req_ready & fu_sel);
  assign sel_done  = |(fu_done & fu_sel);

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
  logic [CTR_W-1:0] ctr_q;
  logic             at_limit;
  assign at_limit = (ctr_q == CTR_W'(TIMEOUT_CYCLES - 1));
  assign fu_abort = timeout ? fu_sel : '0;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)                        ctr_q <= '0;
    else if (state_q == SCARV_COP_DISP_ISSUE) ctr_q <= '0;
    else if (state_q == SCARV_COP_DISP_WAIT)  ctr_q <= ctr_q + 1'b1;
  end
`endif

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_q <= SCARV_COP_DISP_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_exc = 1'b0;
    cap_fu   = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      SCARV_COP_DISP_IDLE: if (cpu_req_valid) begin
        accept = 1'b1;
        if (dec_exc || bad_cls) begin
          load_exc = 1'b1;
          state_d  = SCARV_COP_DISP_RSP;
        end else begin
          state_d  = SCARV_COP_DISP_ISSUE;
        end
      end
      SCARV_COP_DISP_ISSUE: if (sel_ready) begin
        cap_fu  = sel_done;
        state_d = sel_done ? SCARV_COP_DISP_RSP : SCARV_COP_DISP_WAIT;
      end
      SCARV_COP_DISP_WAIT: begin
        // A completion landing on the watchdog limit is still a normal completion.
        if (sel_done) begin
          cap_fu  = 1'b1;
          state_d = SCARV_COP_DISP_RSP;
        end
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
        else if (at_limit) begin
          timeout  = 1'b1;
          load_exc = 1'b1;
          state_d  = SCARV_COP_DISP_RSP;
        end
`endif
      end
      SCARV_COP_DISP_RSP: if (cpu_rsp_ready) state_d = SCARV_COP_DISP_IDLE;
      default: state_d = SCARV_COP_DISP_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      iss_dec   <= '0;
      iss_rs1   <= '0;
      rsp_exc   <= 1'b0;
      rsp_wen   <= 1'b0;
      rsp_wdata <= '0;
    end else begin
      if (accept) begin
        iss_dec <= dec;
        iss_rs1 <= cpu_req_rs1;
      end
      if (load_exc) begin
        rsp_exc   <= 1'b1;
        rsp_wen   <= 1'b0;
        rsp_wdata <= '0;
      end else if (cap_fu) begin
        rsp_exc   <= fu_exc;
        rsp_wen   <= fu_gpr_wen & ~fu_exc;
        rsp_wdata <= fu_gpr_wdata;
      end
    end
  end

  assign cpu_req_ready = (state_q == SCARV_COP_DISP_IDLE);
  assign cpu_rsp_valid = (state_q == SCARV_COP_DISP_RSP);
  assign fu_req_valid  = (state_q == SCARV_COP_DISP_ISSUE) ? fu_sel : '0;
  assign cpu_rsp_exc   = rsp_exc;
  assign cpu_rsp_wen   = rsp_wen;
  assign cpu_rsp_wdata = rsp_wdata;
  assign cpu_rsp_rd    = iss_dec.rd;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Scoreboard bench for scarv_cop_dispatch: expected responses queued at request
// time, popped at each response handshake. Timeout case needs SCARV_COP_DISPATCH_TIMEOUT_EN.
module tb_scarv_cop_dispatch;
  import scarv_cop_dispatch_pkg::*;

  localparam int NFU = 9;

  logic           g_clk = 1'b0;
  logic           g_reset;
  logic           cpu_req_valid, cpu_req_ready;
  logic [31:0]    cpu_req_instr, cpu_req_rs1;
  logic           cpu_rsp_valid, cpu_rsp_ready;
  logic           cpu_rsp_exc, cpu_rsp_wen;
  logic [4:0]     cpu_rsp_rd;
  logic [31:0]    cpu_rsp_wdata;
  dec_t           iss_dec;
  logic [31:0]    iss_rs1;
  logic [NFU-1:0] fu_req_valid, fu_req_ready, fu_done;
  logic           fu_exc, fu_gpr_wen;
  logic [31:0]    fu_gpr_wdata;
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
  logic [NFU-1:0] fu_abort;
`endif

  typedef struct {
    logic        exc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  scarv_cop_dispatch #(
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    .TIMEOUT_CYCLES(8), .CTR_W(4),
`endif
    .NFU(NFU)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_instr(cpu_req_instr), .cpu_req_rs1(cpu_req_rs1),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_exc(cpu_rsp_exc), .cpu_rsp_wen(cpu_rsp_wen),
    .cpu_rsp_rd(cpu_rsp_rd), .cpu_rsp_wdata(cpu_rsp_wdata),
    .iss_dec(iss_dec), .iss_rs1(iss_rs1),
    .fu_req_valid(fu_req_valid), .fu_req_ready(fu_req_ready), .fu_done(fu_done),
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    .fu_abort(fu_abort),
`endif
    .fu_exc(fu_exc), .fu_gpr_wen(fu_gpr_wen), .fu_gpr_wdata(fu_gpr_wdata)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cls, input logic [3:0] sub,
                                     input logic [2:0] pw, input logic [4:0] rd,
                                     input logic [4:0] rs);
    return {cls, sub, 4'h3, rs, pw, rd, SCARV_COP_OPC};
  endfunction

  // Response monitor: one pop per handshake.
  always @(negedge g_clk) begin : mon
    rsp_t e;
    if (!g_reset && cpu_rsp_valid && cpu_rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_exc", cpu_rsp_exc, e.exc);
        chk("sb_wen", cpu_rsp_wen, e.wen);
        chk("sb_rd", cpu_rsp_rd, e.rd);
        if (e.wen) chk("sb_wdata", cpu_rsp_wdata, e.wdata);
      end
    end
  end

  task automatic do_op(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                       input logic illegal, input logic [3:0] cls, input logic [4:0] rd,
                       input int rdy_dly, input int done_dly, input logic f_exc,
                       input logic f_wen, input logic [31:0] f_wdata, input int rsp_dly);
    rsp_t           e;
    logic [NFU-1:0] sel, other;
    logic [3:0]     junk_cls;
    logic [2:0]     pw;
    sel = '0;
    other = '0;
    if (!illegal) begin
      sel[cls - 4'd1] = 1'b1;
      other[int'(cls) % NFU] = 1'b1;
    end
    pw = instr[14:12];
    junk_cls = (cls == CLS_AES) ? CLS_MOVE : CLS_AES;
    e.exc = illegal | f_exc;
    e.wen = !illegal && f_wen && !f_exc;
    e.rd = rd;
    e.wdata = f_wdata;

    chk({tag, "_req_ready"}, cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_instr = instr;
    cpu_req_rs1 = rs1;
    exp_q.push_back(e);
    step();
    cpu_req_valid = 1'b0;
    cpu_req_instr = 32'hFFFF_FFFF;
    cpu_req_rs1 = ~rs1;
    chk({tag, "_iss_cls"}, iss_dec.cls, cls);
    chk({tag, "_iss_rd"}, iss_dec.rd, rd);
    chk({tag, "_iss_pw"}, iss_dec.pw, pw);
    chk({tag, "_iss_rs1"}, iss_rs1, rs1);

    if (illegal) chk({tag, "_ill_fu_idle"}, fu_req_valid, '0);
    else begin
      for (int k = 0; k < rdy_dly; k++) begin
        chk({tag, "_hold_fu_valid"}, fu_req_valid, sel);
        chk({tag, "_hold_iss_cls"}, iss_dec.cls, cls);
        chk({tag, "_hold_req_ready"}, cpu_req_ready, 1'b0);
        step();
      end
      chk({tag, "_fu_valid"}, fu_req_valid, sel);
      fu_req_ready = sel;
      fu_exc = f_exc;
      fu_gpr_wen = f_wen;
      fu_gpr_wdata = f_wdata;
      if (done_dly == 0) fu_done = sel;
      step();
      fu_req_ready = '0;
      fu_done = '0;
      if (done_dly > 0) begin
        for (int k = 1; k < done_dly; k++) begin
          chk({tag, "_wait_fu_valid"}, fu_req_valid, '0);
          chk({tag, "_wait_rsp_valid"}, cpu_rsp_valid, 1'b0);
          fu_done = (k == 1) ? other : '0;
          step();
        end
        chk({tag, "_pre_done_rsp"}, cpu_rsp_valid, 1'b0);
        fu_done = sel;
        step();
        fu_done = '0;
      end
    end

    chk({tag, "_rsp_valid"}, cpu_rsp_valid, 1'b1);
    chk({tag, "_rsp_fu_idle"}, fu_req_valid, '0);
    for (int k = 0; k < rsp_dly; k++) begin
      chk({tag, "_rsp_hold_exc"}, cpu_rsp_exc, e.exc);
      chk({tag, "_rsp_hold_wen"}, cpu_rsp_wen, e.wen);
      chk({tag, "_rsp_hold_rd"}, cpu_rsp_rd, e.rd);
      chk({tag, "_rsp_hold_req_ready"}, cpu_req_ready, 1'b0);
      cpu_req_valid = 1'b1;
      cpu_req_instr = mk(junk_cls, 4'h0, SCARV_COP_PW_1, 5'd9, 5'd1);
      step();
      chk({tag, "_rsp_hold_valid"}, cpu_rsp_valid, 1'b1);
    end
    cpu_rsp_ready = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_instr = mk(junk_cls, 4'h0, SCARV_COP_PW_1, 5'd9, 5'd1);
    step();
    cpu_rsp_ready = 1'b0;
    cpu_req_valid = 1'b0;
    chk({tag, "_post_rsp_valid"}, cpu_rsp_valid, 1'b0);
    chk({tag, "_post_req_ready"}, cpu_req_ready, 1'b1);
    chk({tag, "_post_iss_cls"}, iss_dec.cls, cls);
    chk({tag, "_post_iss_rs1"}, iss_rs1, rs1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, cpu_req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, cpu_rsp_valid, 1'b0);
    chk({tag, "_rsp_exc"}, cpu_rsp_exc, 1'b0);
    chk({tag, "_rsp_wen"}, cpu_rsp_wen, 1'b0);
    chk({tag, "_rsp_rd"}, cpu_rsp_rd, 5'd0);
    chk({tag, "_rsp_wdata"}, cpu_rsp_wdata, 32'd0);
    chk({tag, "_fu_valid"}, fu_req_valid, '0);
    chk({tag, "_iss_dec"}, iss_dec, '0);
    chk({tag, "_iss_rs1"}, iss_rs1, 32'd0);
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    chk({tag, "_fu_abort"}, fu_abort, '0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    g_reset = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_instr = '0;
    cpu_req_rs1 = '0;
    cpu_rsp_ready = 1'b0;
    fu_req_ready = '0;
    fu_done = '0;
    fu_exc = 1'b0;
    fu_gpr_wen = 1'b0;
    fu_gpr_wdata = '0;
    step();
    step();
    chk_reset_state("rst");
    g_reset = 1'b0;
    step();

    do_op("padd", mk(CLS_PACKED_ARITH, 4'h1, SCARV_COP_PW_4, 5'd3, 5'd2), 32'h1111_2222,
          1'b0, CLS_PACKED_ARITH, 5'd3, 0, 2, 1'b0, 1'b0, 32'h0000_1234, 0);
    do_op("move", mk(CLS_MOVE, 4'h0, SCARV_COP_PW_1, 5'd5, 5'd7), 32'hCAFE_0001,
          1'b0, CLS_MOVE, 5'd5, 0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
    do_op("move_same", mk(CLS_MOVE, 4'h2, SCARV_COP_PW_1, 5'd6, 5'd7), 32'h0,
          1'b0, CLS_MOVE, 5'd6, 0, 0, 1'b0, 1'b1, 32'h0BAD_F00D, 0);
    do_op("undef", 32'hFFFF_FFFF, 32'h5, 1'b1, 4'hF, 5'd31, 0, 0, 1'b0, 1'b0, 32'h0, 0);
    do_op("stall", mk(CLS_TWIDDLE, 4'h3, SCARV_COP_PW_2, 5'd10, 5'd4), 32'hA5A5_A5A5,
          1'b0, CLS_TWIDDLE, 5'd10, 5, 1, 1'b0, 1'b1, 32'h1357_9BDF, 0);
    do_op("rsp_bp", mk(CLS_BITWISE, 4'h0, SCARV_COP_PW_1, 5'd12, 5'd1), 32'h7,
          1'b0, CLS_BITWISE, 5'd12, 1, 3, 1'b1, 1'b1, 32'h2468_ACE0, 3);
    do_op("cls0", mk(4'd0, 4'h0, SCARV_COP_PW_1, 5'd1, 5'd1), 32'h9,
          1'b1, 4'd0, 5'd1, 0, 0, 1'b0, 1'b0, 32'h0, 1);
    do_op("cls10", mk(4'd10, 4'h0, SCARV_COP_PW_1, 5'd2, 5'd1), 32'hA,
          1'b1, 4'd10, 5'd2, 0, 0, 1'b0, 1'b0, 32'h0, 0);
    do_op("bad_pw", mk(CLS_PACKED_ARITH, 4'h0, 3'd7, 5'd4, 5'd1), 32'hB,
          1'b1, CLS_PACKED_ARITH, 5'd4, 0, 0, 1'b0, 1'b0, 32'h0, 0);
    do_op("sha3", mk(CLS_SHA3, 4'h1, SCARV_COP_PW_1, 5'd20, 5'd3), 32'hC,
          1'b0, CLS_SHA3, 5'd20, 2, 2, 1'b0, 1'b1, 32'h8000_0001, 1);

    for (int n = 0; n < 24; n++) begin
      logic [3:0] c;
      logic [4:0] r;
      c = 4'($urandom_range(1, NFU));
      r = 5'($urandom_range(0, 31));
      do_op("rnd", mk(c, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 4)), r, 5'd8),
            $urandom, 1'b0, c, r, $urandom_range(0, 3), $urandom_range(0, 4),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
    end

    // Reset while waiting on the FU drops the instruction silently.
    cpu_req_valid = 1'b1;
    cpu_req_instr = mk(CLS_MP, 4'h0, SCARV_COP_PW_1, 5'd17, 5'd2);
    cpu_req_rs1 = 32'h7777_7777;
    step();
    cpu_req_valid = 1'b0;
    fu_req_ready = 9'b000100000;
    step();
    fu_req_ready = '0;
    step();
    chk("wait_rsp_valid", cpu_rsp_valid, 1'b0);
    g_reset = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    step();
    g_reset = 1'b0;
    step();
    chk("post_rst_req_ready", cpu_req_ready, 1'b1);

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    begin
      rsp_t e;
      e.exc = 1'b1;
      e.wen = 1'b0;
      e.rd = 5'd14;
      e.wdata = '0;
      exp_q.push_back(e);
      cpu_req_valid = 1'b1;
      cpu_req_instr = mk(CLS_RANDOM, 4'h0, SCARV_COP_PW_1, 5'd14, 5'd2);
      step();
      cpu_req_valid = 1'b0;
      fu_req_ready = 9'b000001000;
      step();
      fu_req_ready = '0;
      for (int k = 0; k < 7; k++) begin
        chk("to_abort_early", fu_abort, '0);
        chk("to_rsp_early", cpu_rsp_valid, 1'b0);
        step();
      end
      chk("to_abort_pulse", fu_abort, 9'b000001000);
      step();
      chk("to_abort_clear", fu_abort, '0);
      chk("to_rsp_valid", cpu_rsp_valid, 1'b1);
      cpu_rsp_ready = 1'b1;
      step();
      cpu_rsp_ready = 1'b0;
    end
`endif

    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
